spi_ram_ctrl: RTL
=================

// Module: spi_ram_ctrl
// PURPOSE
//  Downstream stage of the SPI slave FSM: a single-port synchronous RAM plus command decoder.
//  Consumes the 10-bit deserialised word (rx_data/rx_valid) and returns read data (tx_data/tx_valid).
//  din[9:8] selects the command: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data; din[7:0] is the payload.
//  Holds read data stable while the SPI slave serialises it onto MISO.
// PARAMETERS
//  MEM_DEPTH      256  number of words; must equal 2**ADDR_SIZE
//  ADDR_SIZE      8    address width; payload bits [ADDR_SIZE-1:0] are used as the address
//  TX_HOLD        10   number of cycles tx_valid stays high per read (1 RAM latency + 9 serialise)
//  AUTO_INC       0    1: post-increment wr_addr after each write and rd_addr after each read (wraps)
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   reset, synchronous, active-low
//  din       in   10  command[9:8] + payload[7:0] from the SPI slave rx_data
//  rx_valid  in   1   din is valid this cycle; one command is processed per high cycle
//  dout      out  8   read data to the SPI slave tx_data
//  tx_valid  out  1   dout valid; held high for TX_HOLD cycles per accepted read
//  seq_err   out  1   sticky: data command with no address loaded, or read during hold
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): dout=0, tx_valid=0, seq_err=0, wr_addr=rd_addr=0, wr_ok=rd_ok=0,
//   state=IDLE, hold_cnt=0. RAM contents are not reset. Reset wins over every other event.
//  rx_valid=0: no state change except the hold counter.
//  CMD 00: wr_addr<=din[ADDR_SIZE-1:0]; wr_ok<=1.
//  CMD 01: if wr_ok, mem[wr_addr]<=din[7:0] at this edge (plus wr_addr+1 mod MEM_DEPTH if AUTO_INC);
//   otherwise drop the write and set seq_err<=1.
//  CMD 10: rd_addr<=din[ADDR_SIZE-1:0]; rd_ok<=1.
//  CMD 11 in IDLE with rd_ok: dout<=mem[rd_addr] and tx_valid<=1 at the same edge (1-cycle latency
//   from rx_valid); state<=HOLD; hold_cnt<=TX_HOLD-1; rd_addr+1 if AUTO_INC. din[7:0] is ignored.
//  CMD 11 in IDLE with rd_ok=0: no read, tx_valid stays 0, seq_err<=1.
//  FSM IDLE->HOLD on accepted read. In HOLD, hold_cnt decrements each cycle.
//   At hold_cnt==0: tx_valid<=0 and state<=IDLE. tx_valid is therefore high for exactly TX_HOLD cycles.
//  In HOLD: dout stays stable. CMD 00/01/10 are processed normally.
//   CMD 11 is dropped, sets seq_err, and does not extend the hold.
//  Read-after-write to the same address on a later cycle returns the new data.
//   No same-cycle hazard exists because there is one command per cycle.
//  Address registers wrap MEM_DEPTH-1 -> 0. dout keeps its last value after tx_valid falls.
//  wr_ok/rd_ok stay set until reset; an address stays loaded across any number of data commands.
//  Reset during HOLD: tx_valid=0 and state=IDLE at that edge. Any command in the same cycle is discarded.
// STRUCTURE
//  Shared package/include spi_ram_defs: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01,
//   CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11, and state encodings IDLE/HOLD.
//   The SPI slave uses the same command constants.
//  Sub-module spi_ram_mem: single-port synchronous RAM (we, addr, wdata, rdata, 1-cycle read).
//   The controller holds the decoder, address registers, flags, FSM and hold counter.
// TESTING
//  1. Reset, then 00_0x10, 01_0xA5, 10_0x10, 11_xx -> tx_valid rises 1 cycle after the 11 command
//     with dout=0xA5, stays high 10 cycles, then falls; seq_err=0.
//  2. After reset, 01_0x33 with no address loaded -> RAM unchanged, seq_err=1; a later read of addr 0 returns old contents.
//  3. After reset, 11_xx with no read address loaded -> tx_valid stays 0 for 20 cycles, seq_err=1.
//  4. During HOLD send 11_xx -> dout unchanged, tx_valid falls on schedule (10 cycles total), seq_err=1.
//     During HOLD send 00_0x20, 01_0x5A -> mem[0x20]=0x5A, confirmed by a later read.
//  5. AUTO_INC=1: 00_0xFF, 01_0x11, 01_0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap); reading from 10_0xFF gives 0x11 then 0x22.
//  6. Assert rst_n=0 on the 4th cycle of HOLD -> tx_valid=0 at that edge, dout=0; a fresh read afterwards works normally.

Source files
------------

// File: rtl/spi_ram_defs.sv
// Shared command and state definitions for the SPI RAM controller and the SPI slave.
package spi_ram_defs;

    localparam int unsigned CMD_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = CMD_W + DATA_W;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered, enable-gated read data.
module spi_ram_mem
    import spi_ram_defs::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array has no reset so it maps onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only loads on re, so it holds the word while it is serialised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder, address registers and read-hold FSM in front of the SPI RAM.
module spi_ram_ctrl
    import spi_ram_defs::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TX_HOLD   = 10,
    parameter int unsigned AUTO_INC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              seq_err
);

    localparam int unsigned CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_ok;
    logic                 rd_ok;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              tx_valid_d;

    logic                 wr_accept;
    logic                 rd_accept;
    logic                 seq_fault;
    logic                 ram_we;
    logic                 ram_re;
    logic [ADDR_SIZE-1:0] ram_addr;

    assign cmd     = cmd_e'(din[WORD_W-1:DATA_W]);
    assign payload = din[DATA_W-1:0];

    assign wr_accept = rx_valid && (cmd == CMD_WR_DATA) && wr_ok;
    assign rd_accept = rx_valid && (cmd == CMD_RD_DATA) && rd_ok && (state_q == IDLE);
    assign seq_fault = rx_valid &&
                       (((cmd == CMD_WR_DATA) && !wr_ok) ||
                        ((cmd == CMD_RD_DATA) && (!rd_ok || (state_q == HOLD))));

    // Reset discards any command arriving in the same cycle, RAM write included.
    assign ram_we   = rst_n && wr_accept;
    assign ram_re   = rst_n && rd_accept;
    assign ram_addr = (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;

    spi_ram_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (payload),
        .rdata (dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
            wr_ok   <= 1'b0;
            rd_ok   <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr <= din[ADDR_SIZE-1:0];
                        wr_ok   <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (wr_ok && (AUTO_INC != 0)) begin
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                        end
                    end
                    CMD_RD_ADDR: begin
                        rd_addr <= din[ADDR_SIZE-1:0];
                        rd_ok   <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        if (rd_accept && (AUTO_INC != 0)) begin
                            rd_addr <= rd_addr + ADDR_SIZE'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if (seq_fault) begin
                seq_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            tx_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tx_valid   <= tx_valid_d;
        end
    end

    // Counter loads TX_HOLD-1 and releases at zero, giving exactly TX_HOLD valid cycles.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tx_valid_d = tx_valid;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    state_d    = HOLD;
                    hold_cnt_d = CNT_W'(TX_HOLD - 1);
                    tx_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

endmodule
